// File: rtl/cdc_pulse_scheduler.sv
// Round-robin scheduler sharing one fast-to-slow pulse-CDC channel between N_REQ requesters.
// Optional saturating overrun counter: define CDC_SCHED_OVR_COUNT_EN.

module cdc_sched_lane (
  input  logic Clk_Fast,
  input  logic Rst,
  input  logic req,
  input  logic clr,
  input  logic ovr_clr,
  output logic pending,
  output logic overrun,
  output logic ovr_evt
);
  // A request landing on the grant-clear edge is a fresh event, not an overrun
  assign ovr_evt = req & pending & ~clr;

  always_ff @(posedge Clk_Fast or posedge Rst) begin
    if (Rst) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pending <= req | (pending & ~clr);
      overrun <= ovr_evt | (overrun & ~ovr_clr);
    end
  end
endmodule

module cdc_pulse_scheduler #(
  parameter int N_REQ             = 4,
  parameter int FAST_CLK_FREQ_MHZ = 100,
  parameter int SLOW_CLK_FREQ_MHZ = 12,
  parameter int GUARD_CYCLES      = 4,
  localparam int IDW              = $clog2(N_REQ)
) (
  input  logic             Clk_Fast,
  input  logic             Rst,
  input  logic             Enable,
  input  logic [N_REQ-1:0] Req,
  input  logic             Overrun_Clr,
  output logic             Cdc_Pulse,
  output logic [IDW-1:0]   Chan_Id,
  output logic             Busy,
  output logic [N_REQ-1:0] Pending,
  output logic [N_REQ-1:0] Overrun,
  output logic [7:0]       Ovr_Count
);
  localparam int RATIO   = FAST_CLK_FREQ_MHZ / SLOW_CLK_FREQ_MHZ;
  localparam int EXTEND  = RATIO + RATIO / 2;
  localparam int SPACING = 2 * (EXTEND + 1) + GUARD_CYCLES;
  localparam int CW      = $clog2(SPACING);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLD} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IDW-1:0]   ptr, ptr_n;
  logic [IDW-1:0]   id_n;
  logic             pulse_n, busy_n;
  logic             grant_found, do_grant;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] clr_vec;
  logic [N_REQ-1:0] ovr_evt;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      cdc_sched_lane u_lane (
        .Clk_Fast (Clk_Fast),
        .Rst      (Rst),
        .req      (Req[gi]),
        .clr      (clr_vec[gi]),
        .ovr_clr  (Overrun_Clr),
        .pending  (Pending[gi]),
        .overrun  (Overrun[gi]),
        .ovr_evt  (ovr_evt[gi])
      );
    end
  endgenerate

  // First pending requester after the last grant, wrapping around
  always_comb begin
    int s;
    logic [IDW-1:0] sel;
    grant_found = 1'b0;
    grant_id    = ptr;
    s           = 0;
    sel         = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      s   = (int'(ptr) + k) % N_REQ;
      sel = s[IDW-1:0];
      if (!grant_found && Pending[sel]) begin
        grant_found = 1'b1;
        grant_id    = sel;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ptr_n    = ptr;
    id_n     = Chan_Id;
    pulse_n  = 1'b0;
    busy_n   = Busy;
    do_grant = 1'b0;
    case (state)
      S_IDLE: begin
        if (Enable && grant_found) do_grant = 1'b1;
      end
      S_PULSE: begin
        state_n = S_HOLD;
        cnt_n   = CW'(SPACING - 2);
        busy_n  = 1'b1;
      end
      S_HOLD: begin
        // The final holdoff edge doubles as the IDLE decision so queued events stay SPACING apart
        if (cnt == '0) begin
          if (Enable && grant_found) begin
            do_grant = 1'b1;
          end else begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
    if (do_grant) begin
      state_n = S_PULSE;
      pulse_n = 1'b1;
      busy_n  = 1'b1;
      id_n    = grant_id;
      ptr_n   = grant_id;
    end
  end

  assign clr_vec = do_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;

  always_ff @(posedge Clk_Fast or posedge Rst) begin
    if (Rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= IDW'(N_REQ - 1);
      Cdc_Pulse <= 1'b0;
      Busy      <= 1'b0;
      Chan_Id   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      Cdc_Pulse <= pulse_n;
      Busy      <= busy_n;
      Chan_Id   <= id_n;
    end
  end

`ifdef CDC_SCHED_OVR_COUNT_EN
  logic [4:0] ovr_inc;
  logic [8:0] ovr_sum;

  always_comb begin
    ovr_inc = '0;
    for (int i = 0; i < N_REQ; i++) ovr_inc = ovr_inc + {4'b0, ovr_evt[i]};
    ovr_sum = {1'b0, Ovr_Count} + {4'b0, ovr_inc};
  end

  // Clear restarts from this cycle's events so a coincident overrun is still counted
  always_ff @(posedge Clk_Fast or posedge Rst) begin
    if (Rst)              Ovr_Count <= 8'd0;
    else if (Overrun_Clr) Ovr_Count <= {3'b0, ovr_inc};
    else if (ovr_sum[8])  Ovr_Count <= 8'd255;
    else                  Ovr_Count <= ovr_sum[7:0];
  end
`else
  logic unused_ovr_evt;
  assign unused_ovr_evt = ^ovr_evt;
  assign Ovr_Count      = 8'd0;
`endif

endmodule
